// File: rtl/apb_mem_bridge_if.sv
// apb_mem_bridge_if: APB4 completer bus plus single-cycle memory port
// slave modport (bridge view):
//   in : psel, penable, pwrite, paddr, pwdata, pstrb, mem_rd_data
//   out: pready, prdata, pslverr, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data, mem_strb
// master modport: the same signals seen from the requester/memory side
interface apb_mem_bridge_if #(
  parameter int PADDR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8
);
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [PADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0]  pwdata;
  logic [STRB_WIDTH-1:0]  pstrb;
  logic                   pready;
  logic [DATA_WIDTH-1:0]  prdata;
  logic                   pslverr;
  logic                   mem_wr_en;
  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_wr_data;
  logic [STRB_WIDTH-1:0]  mem_strb;
  logic [DATA_WIDTH-1:0]  mem_rd_data;
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, mem_rd_data,
    output pready, prdata, pslverr, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data, mem_strb
  );
  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, mem_rd_data,
    input  pready, prdata, pslverr, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data, mem_strb
  );
endinterface

// File: rtl/apb_mem_bridge.sv
// apb_mem_bridge: APB4 completer driving single-cycle memory strobes with range/alignment checks and wait states
// ports: pclk clock, preset sync active-high reset, bus = apb_mem_bridge_if.slave (APB side + memory side)
module apb_mem_bridge #(
  parameter int PADDR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic pclk,
  input logic preset,
  apb_mem_bridge_if.slave bus
);
  localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  localparam logic [PADDR_WIDTH-3:0] LIM = (PADDR_WIDTH-2)'(MEM_WORDS);
  localparam bit W0 = WAIT_STATES == 0;
  typedef enum logic [1:0] {IDLE, ACC, RDW, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_write, r_err, r_rd_a2;
  logic r_pready, r_pslverr, r_wr_en, r_rd_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [STRB_WIDTH-1:0] r_strb;
  logic w_setup, w_err, w_last;
  logic w_pready_n, w_pslverr_n, w_wr_en_n, w_rd_en_n;
  assign w_setup = r_state == IDLE && bus.psel && !bus.penable;
  assign w_err   = |bus.paddr[1:0] || bus.paddr[PADDR_WIDTH-1:2] >= LIM;
  assign w_last  = r_cnt == LAST;
  // ACC holds the wait cycles of writes/errors; reads spend one ACC cycle then wait in RDW
  always_comb begin
    w_next = r_state == IDLE ? (w_setup ? (((bus.pwrite || w_err) && W0) ? DONE : ACC) : IDLE)
           : r_state == DONE ? IDLE
           : !bus.psel ? IDLE
           : r_state == RDW ? (w_last ? DONE : RDW)
           : (r_write || r_err) ? (w_last ? DONE : ACC)
           : (W0 ? DONE : RDW);
    w_cnt = (r_state == RDW || (r_state == ACC && (r_write || r_err))) ? r_cnt + 1'b1 : '0;
  end
  // outputs are registered from the next state so pready lands in the DONE cycle itself
  always_comb begin
    w_pready_n  = w_next == DONE;
    w_pslverr_n = w_next == DONE && (r_state == IDLE ? w_err : r_err);
    w_wr_en_n   = w_setup && !w_err && bus.pwrite;
    w_rd_en_n   = w_setup && !w_err && !bus.pwrite;
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_rd_a2   <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt;
      r_pready  <= w_pready_n;
      r_pslverr <= w_pslverr_n;
      r_wr_en   <= w_wr_en_n;
      r_rd_en   <= w_rd_en_n;
      r_rd_a2   <= r_rd_en;
      if (w_setup) begin
        r_write <= bus.pwrite;
        r_err   <= w_err;
      end
      if (w_wr_en_n || w_rd_en_n) begin
        r_addr  <= bus.paddr[ADDR_WIDTH+1:2];
        r_wdata <= bus.pwdata;
        r_strb  <= bus.pwrite ? bus.pstrb : '0;
      end
      if (r_rd_a2) r_rdata <= bus.mem_rd_data;
    end
  end
  // read data is only guaranteed the cycle after the strobe, so later DONE cycles use the captured copy
  assign bus.prdata      = (r_pready && !r_write && !r_err) ? (r_rd_a2 ? bus.mem_rd_data : r_rdata) : '0;
  assign bus.pready      = r_pready;
  assign bus.pslverr     = r_pslverr;
  assign bus.mem_wr_en   = r_wr_en;
  assign bus.mem_rd_en   = r_rd_en;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wr_data = r_wdata;
  assign bus.mem_strb    = r_strb;
endmodule

// File: tb/tb_apb_mem_bridge.sv
// tb_apb_mem_bridge: directed bench for apb_mem_bridge with 0, 3 and 2 wait states sharing one memory model
module tb_apb_mem_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic preset, psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0] pstrb;
  logic [1:0] sel;
  logic [31:0] rd_data;
  logic [31:0] mem [0:1023];
  int n_asrt = 0, n_fail = 0, wr_cnt = 0, rd_cnt = 0;
  apb_mem_bridge_if bi [3] ();
  logic [3:0] rdy_v, err_v, wr_v, rd_v;
  logic [31:0] prd_a [4], wd_a [4];
  logic [29:0] addr_a [4];
  logic [3:0] st_a [4];
  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int W = (k == 0) ? 0 : (k == 1) ? 3 : 2;
    assign bi[k].psel        = psel && (sel == 2'(k));
    assign bi[k].penable     = penable;
    assign bi[k].pwrite      = pwrite;
    assign bi[k].paddr       = paddr;
    assign bi[k].pwdata      = pwdata;
    assign bi[k].pstrb       = pstrb;
    assign bi[k].mem_rd_data = rd_data;
    assign rdy_v[k]  = bi[k].pready;
    assign err_v[k]  = bi[k].pslverr;
    assign wr_v[k]   = bi[k].mem_wr_en;
    assign rd_v[k]   = bi[k].mem_rd_en;
    assign prd_a[k]  = bi[k].prdata;
    assign wd_a[k]   = bi[k].mem_wr_data;
    assign addr_a[k] = bi[k].mem_addr;
    assign st_a[k]   = bi[k].mem_strb;
    apb_mem_bridge #(.WAIT_STATES(W)) dut (.pclk(clk), .preset(preset), .bus(bi[k]));
  end
  assign rdy_v[3] = 1'b0;
  assign err_v[3] = 1'b0;
  assign wr_v[3] = 1'b0;
  assign rd_v[3] = 1'b0;
  assign prd_a[3] = '0;
  assign wd_a[3] = '0;
  assign addr_a[3] = '0;
  assign st_a[3] = '0;
  logic m_pready, m_pslverr, m_wr, m_rd;
  logic [31:0] m_prdata, m_wdata;
  logic [29:0] m_addr;
  logic [3:0] m_strb;
  assign m_pready  = rdy_v[sel];
  assign m_pslverr = err_v[sel];
  assign m_wr      = wr_v[sel];
  assign m_rd      = rd_v[sel];
  assign m_prdata  = prd_a[sel];
  assign m_wdata   = wd_a[sel];
  assign m_addr    = addr_a[sel];
  assign m_strb    = st_a[sel];
  always @(posedge clk) begin
    if (m_wr) for (int j = 0; j < 4; j++) if (m_strb[j]) mem[m_addr[9:0]][8*j +: 8] <= m_wdata[8*j +: 8];
    if (m_rd) rd_data <= mem[m_addr[9:0]];
  end
  always @(negedge clk) begin
    if (m_wr) wr_cnt <= wr_cnt + 1;
    if (m_rd) rd_cnt <= rd_cnt + 1;
  end
  int cyc, c0;
  logic [31:0] rdat;
  logic serr, a1_wr, a1_rd, after_rdy, hit;
  logic [29:0] a1_addr;
  logic [3:0] a1_strb;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // called at posedge+1; returns at posedge+1 of the idle cycle following completion
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge clk) after_rdy = m_pready;
    @(posedge clk); #1 penable = 1'b1;
    cyc = 0; rdat = 'x; serr = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin a1_wr = m_wr; a1_rd = m_rd; a1_addr = m_addr; a1_strb = m_strb; end
      if (m_pready) begin cyc = i; rdat = m_prdata; serr = m_pslverr; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; sel = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", 32'(m_pready), 0);
    chk("rst_pslverr", 32'(m_pslverr), 0);
    chk("rst_wr_en", 32'(m_wr), 0);
    chk("rst_rd_en", 32'(m_rd), 0);
    @(posedge clk); #1 preset = 1'b0;
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("w0_wr_lat", cyc, 1);
    chk("w0_wr_err", 32'(serr), 0);
    chk("w0_wr_strobe", 32'(a1_wr), 1);
    chk("w0_wr_addr", 32'(a1_addr), 4);
    chk("w0_wr_strb", 32'(a1_strb), 32'hF);
    xfer(1'b0, 32'h10, 32'h0, 4'h0);
    chk("w0_pready_one_cycle", 32'(after_rdy), 0);
    chk("w0_rd_lat", cyc, 2);
    chk("w0_rd_strobe", 32'(a1_rd), 1);
    chk("w0_rd_data", rdat, 32'hDEADBEEF);
    chk("w0_rd_err", 32'(serr), 0);
    xfer(1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
    xfer(1'b1, 32'h20, 32'h11223344, 4'b0101);
    xfer(1'b0, 32'h20, 32'h0, 4'hF);
    chk("partial_rd_data", rdat, 32'hDE22BE44);
    chk("rd_strb_ignored", 32'(a1_strb), 0);
    xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    chk("zstrb_lat", cyc, 1);
    chk("zstrb_err", 32'(serr), 0);
    chk("zstrb_strobe", 32'(a1_wr), 1);
    chk("zstrb_mem_strb", 32'(a1_strb), 0);
    xfer(1'b0, 32'h20, 32'h0, 4'h0);
    chk("zstrb_unchanged", rdat, 32'hDE22BE44);
    xfer(1'b1, 32'h0, 32'h01020304, 4'hF);
    c0 = rd_cnt;
    xfer(1'b0, 32'h13, 32'h0, 4'h0);
    chk("mis_lat", cyc, 1);
    chk("mis_err", 32'(serr), 1);
    chk("mis_prdata", rdat, 0);
    chk("mis_no_rd", rd_cnt, c0);
    c0 = wr_cnt;
    xfer(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    chk("oor_lat", cyc, 1);
    chk("oor_err", 32'(serr), 1);
    chk("oor_no_wr", wr_cnt, c0);
    xfer(1'b0, 32'h0, 32'h0, 4'h0);
    chk("oor_mem_kept", rdat, 32'h01020304);
    sel = 2'd1;
    xfer(1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    chk("w3_wr_lat", cyc, 4);
    chk("w3_wr_err", 32'(serr), 0);
    xfer(1'b0, 32'h30, 32'h0, 4'h0);
    chk("w3_wr_pready_one", 32'(after_rdy), 0);
    chk("w3_rd_lat", cyc, 5);
    chk("w3_rd_data", rdat, 32'hCAFEF00D);
    xfer(1'b0, 32'h10, 32'h0, 4'h0);
    chk("w3_rd_pready_one", 32'(after_rdy), 0);
    chk("w3_rd2_lat", cyc, 5);
    chk("w3_rd2_data", rdat, 32'hDEADBEEF);
    sel = 2'd2;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    hit = 1'b0;
    repeat (8) @(negedge clk) if (m_pready) hit = 1'b1;
    chk("abort_no_pready", 32'(hit), 0);
    @(posedge clk); #1;
    xfer(1'b0, 32'h30, 32'h0, 4'h0);
    chk("abort_next_lat", cyc, 4);
    chk("abort_next_data", rdat, 32'hCAFEF00D);
    xfer(1'b1, 32'h40, 32'hA5A5A5A5, 4'hF);
    chk("w2_wr_lat", cyc, 3);
    xfer(1'b0, 32'h40, 32'h0, 4'h0);
    chk("w2_rd_data", rdat, 32'hA5A5A5A5);
    sel = 2'd0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1; preset = 1'b1;
    @(posedge clk); #1 preset = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("mrst_pready", 32'(m_pready), 0);
    chk("mrst_pslverr", 32'(m_pslverr), 0);
    chk("mrst_wr_en", 32'(m_wr), 0);
    chk("mrst_rd_en", 32'(m_rd), 0);
    chk("mrst_addr", 32'(m_addr), 0);
    chk("mrst_wdata", m_wdata, 0);
    chk("mrst_strb", 32'(m_strb), 0);
    chk("mrst_prdata", m_prdata, 0);
    @(posedge clk); #1;
    xfer(1'b1, 32'h0, 32'h55AA55AA, 4'hF);
    chk("mrst_wr_lat", cyc, 1);
    chk("mrst_wr_err", 32'(serr), 0);
    xfer(1'b0, 32'h0, 32'h0, 4'h0);
    chk("mrst_rd_lat", cyc, 2);
    chk("mrst_rd_data", rdat, 32'h55AA55AA);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
